icx_exposure_ctrl: RTL
======================

ICX_EXPOSURE_CTRL -- requirements
Module: icx_exposure_ctrl

Interface
REQ-001 SHALL have parameter LINE_PERIOD, default 1132, clk cycles per line-time unit (<=4095).
REQ-002 SHALL have parameter SUB_WIDTH, default 54, xsub pulse width in cycles (<LINE_PERIOD).
REQ-003 SHALL have parameter CLEAR_LINES, default 4, number of line-times spent flushing the sensor.
REQ-004 SHALL have parameter TIMEOUT, default 1300000, max READ duration in cycles (<2^22).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, request one exposure; sampled in IDLE only.
REQ-008 SHALL have port abort, input, 1, cancel the sequence.
REQ-009 SHALL have port continuous, input, 1, re-arm after each frame.
REQ-010 SHALL have port exp_lines, input, 16, exposure length in line-times.
REQ-011 SHALL have port frame_done, input, 1, timing generator finished frame readout.
REQ-012 SHALL have port tg_reset, output, 1, high holds the timing generator in reset.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse starting readout.
REQ-014 SHALL have port xsub, output, 1, electronic-shutter substrate pulse.
REQ-015 SHALL have ports busy (1), done (1), err (1), state (3), frame_cnt (8), all outputs: status, frame-complete pulse, sticky timeout, current state, frames completed.

Function
REQ-016 SHALL use states IDLE=0, CLEAR=1, EXPOSE=2, READ=3, FINISH=4; state output equals current state; encodings 5-7 SHALL return to IDLE next cycle.
REQ-017 SHALL keep a 12-bit cycle counter (0..LINE_PERIOD-1, wraps) and a 16-bit line counter, both zeroed on every state entry.
REQ-018 IDLE: start=1 and abort=0 SHALL latch exp_lines (0 latched as 1), clear err, enter CLEAR next cycle; start ignored in all other states.
REQ-019 CLEAR: xsub SHALL be 1 exactly while cycle counter < SUB_WIDTH; after CLEAR_LINES*LINE_PERIOD cycles SHALL enter EXPOSE.
REQ-020 EXPOSE: xsub=0; after latched_lines*LINE_PERIOD cycles SHALL enter READ.
REQ-021 READ: tg_reset=0; frame_start=1 only in first READ cycle; frame_done=1 SHALL enter FINISH.
REQ-022 READ lasting TIMEOUT cycles without frame_done SHALL set err=1 and enter IDLE; err sticky until next accepted start or reset.
REQ-023 FINISH (one cycle): done=1, frame_cnt incremented (255 wraps to 0); next state CLEAR with fresh exp_lines latch if continuous=1, else IDLE.
REQ-024 tg_reset SHALL be 1 in every state except READ; busy SHALL be 1 in every state except IDLE.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE next cycle: xsub=0, tg_reset=1, no done, frame_cnt unchanged.
REQ-026 abort and frame_done in the same cycle: abort wins; no FINISH, no count.
REQ-027 All outputs SHALL derive only from registers (no combinational input-to-output path).

Reset
REQ-028 reset=1 SHALL immediately set state=IDLE, tg_reset=1, frame_start=0, xsub=0, busy=0, done=0, err=0, frame_cnt=0, all counters and latched_lines=0, including mid-sequence.
REQ-029 After reset deasserts, first start SHALL be accepted on the first rising edge it is sampled high.

Verification (LINE_PERIOD=10, SUB_WIDTH=3, CLEAR_LINES=2, TIMEOUT=100)
REQ-030 start at cycle 0, exp_lines=3, frame_done at cycle 60 -> CLEAR 1-20, xsub high 1-3 and 11-13, EXPOSE 21-50, frame_start at 51, done at 61, frame_cnt=1, IDLE at 62.
REQ-031 exp_lines=0 -> EXPOSE lasts exactly 10 cycles.
REQ-032 continuous=1, frame_done 9 cycles after each frame_start -> second CLEAR 62-81, EXPOSE 82-111, frame_start at 112; continuous=0 before second FINISH -> IDLE, frame_cnt=2.
REQ-033 abort at cycle 30 (EXPOSE) -> IDLE at 31, tg_reset=1, done never asserted; abort coincident with frame_done -> frame_cnt unchanged.
REQ-034 frame_done withheld -> err=1 and IDLE after 100 READ cycles; next start clears err; reset asserted mid-CLEAR -> all outputs at reset values same cycle.
REQ-035 256 single-shot frames -> frame_cnt wraps to 0; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/icx_exposure_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icx_exposure_ctrl
//  Description : Exposure sequencer for an interline CCD. Flushes the sensor
//                with substrate (xsub) pulses, integrates for a programmable
//                number of line-times, then releases the timing generator for
//                readout and waits for frame completion with a timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module icx_exposure_ctrl #(
    parameter int LINE_PERIOD = 1132,
    parameter int SUB_WIDTH   = 54,
    parameter int CLEAR_LINES = 4,
    parameter int TIMEOUT     = 1300000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        continuous,
    input  logic [15:0] exp_lines,
    input  logic        frame_done,
    output logic        tg_reset,
    output logic        frame_start,
    output logic        xsub,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  state,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_EXPOSE = 3'd2,
        ST_READ   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [11:0] c_lp_last      = 12'(LINE_PERIOD - 1);
    localparam logic [11:0] c_sub_width    = 12'(SUB_WIDTH);
    localparam logic [15:0] c_clear_last   = 16'(CLEAR_LINES - 1);
    localparam logic [21:0] c_timeout_last = 22'(TIMEOUT - 1);

    state_t      r_state;
    logic [11:0] r_cyc;
    logic [15:0] r_line;
    logic [21:0] r_rd;
    logic [15:0] r_lines;
    logic        r_err;
    logic        r_tg_reset;
    logic        r_frame_start;
    logic        r_xsub;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_frame_cnt;

    state_t      w_next;
    logic [15:0] w_lines;
    logic        w_err;
    logic        w_line_end;
    logic [15:0] w_exp_latch;
    logic [11:0] w_cyc_n;
    logic [15:0] w_line_n;
    logic [21:0] w_rd_n;

    // Next-state decode; every exit path out of a busy state honours abort first
    always_comb begin
        w_next      = r_state;
        w_lines     = r_lines;
        w_err       = r_err;
        w_line_end  = (r_cyc == c_lp_last);
        // A zero exposure request is treated as the minimum of one line-time
        w_exp_latch = (exp_lines == 16'd0) ? 16'd1 : exp_lines;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_next  = ST_CLEAR;
                    w_lines = w_exp_latch;
                    w_err   = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (abort)
                    w_next = ST_IDLE;
                else if (w_line_end && (r_line == c_clear_last))
                    w_next = ST_EXPOSE;
            end
            ST_EXPOSE: begin
                if (abort)
                    w_next = ST_IDLE;
                else if (w_line_end && (r_line == (r_lines - 16'd1)))
                    w_next = ST_READ;
            end
            ST_READ: begin
                if (abort)
                    w_next = ST_IDLE;
                else if (frame_done)
                    w_next = ST_FINISH;
                else if (r_rd == c_timeout_last) begin
                    w_next = ST_IDLE;
                    w_err  = 1'b1;
                end
            end
            ST_FINISH: begin
                if (abort)
                    w_next = ST_IDLE;
                else if (continuous) begin
                    w_next  = ST_CLEAR;
                    w_lines = w_exp_latch;
                end else
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Counters restart on every state entry and rest at zero while idle
    always_comb begin
        w_cyc_n  = 12'd0;
        w_line_n = 16'd0;
        w_rd_n   = 22'd0;
        if ((w_next == r_state) && (w_next != ST_IDLE)) begin
            w_cyc_n  = w_line_end ? 12'd0 : (r_cyc + 12'd1);
            w_line_n = w_line_end ? (r_line + 16'd1) : r_line;
            w_rd_n   = r_rd + 22'd1;
        end
    end

    // State, counters and outputs all registered from next-state values so
    // outputs line up with the state they describe and have no input path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cyc         <= 12'd0;
            r_line        <= 16'd0;
            r_rd          <= 22'd0;
            r_lines       <= 16'd0;
            r_err         <= 1'b0;
            r_tg_reset    <= 1'b1;
            r_frame_start <= 1'b0;
            r_xsub        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frame_cnt   <= 8'd0;
        end else begin
            r_state       <= w_next;
            r_cyc         <= w_cyc_n;
            r_line        <= w_line_n;
            r_rd          <= w_rd_n;
            r_lines       <= w_lines;
            r_err         <= w_err;
            r_tg_reset    <= (w_next != ST_READ);
            r_frame_start <= (w_next == ST_READ) && (r_state != ST_READ);
            r_xsub        <= (w_next == ST_CLEAR) && (w_cyc_n < c_sub_width);
            r_busy        <= (w_next != ST_IDLE);
            r_done        <= (w_next == ST_FINISH);
            if (w_next == ST_FINISH)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign state       = r_state;
    assign tg_reset    = r_tg_reset;
    assign frame_start = r_frame_start;
    assign xsub        = r_xsub;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
